// File: rtl/mem_arb_pkg.sv
// Shared types for the data RAM arbiter: FSM state encoding and requester IDs.
package mem_arb_pkg;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
  localparam logic REQ_LSU = 1'b0;
  localparam logic REQ_DBG = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick; a held lock lets the previous winner keep priority.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_held,
  output logic       valid,
  output logic       winner
);
  always_comb begin
    valid = |req;
    if (lock_held && req[last]) winner = last;
    else if (&req)              winner = ~last;
    else                        winner = req[1];
  end
endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port data RAM between the LSU (0) and the debug/loader port (1).
// Each access is an IDLE (arbitrate/latch) -> ACCESS (drive RAM, grant) pair.
module data_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  we0_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  input  logic                  lock0_i,
  input  logic                  lock1_i,
  output logic                  gnt0_o,
  output logic                  gnt1_o,
  output logic                  rvalid0_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_we_o,
  input  logic [DATA_WIDTH-1:0] ram_q_i
);
  state_t     state;
  logic       owner, we_q, last, lock_held;
  logic       valid, winner;
  logic [1:0] req, rvalid_q;

  assign req = {req1_i, req0_i};

  rr_arbiter2 u_arb (
    .req       (req),
    .last      (last),
    .lock_held (lock_held),
    .valid     (valid),
    .winner    (winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= REQ_LSU;
      we_q       <= 1'b0;
      last       <= REQ_DBG;
      lock_held  <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      rvalid_q   <= '0;
    end else begin
      rvalid_q <= '0;
      if (state == IDLE) begin
        // lock survives only while its holder keeps requesting
        lock_held <= lock_held & req[last];
        if (valid) begin
          state      <= ACCESS;
          owner      <= winner;
          last       <= winner;
          lock_held  <= winner ? lock1_i  : lock0_i;
          we_q       <= winner ? we1_i    : we0_i;
          ram_addr_o <= winner ? addr1_i  : addr0_i;
          ram_data_o <= winner ? wdata1_i : wdata0_i;
        end
      end else begin
        state <= IDLE;
        if (!we_q) rvalid_q[owner] <= 1'b1;
      end
    end
  end

  // Decoded from state so reset drops gnt/we without waiting for an edge
  assign gnt0_o    = (state == ACCESS) && (owner == REQ_LSU);
  assign gnt1_o    = (state == ACCESS) && (owner == REQ_DBG);
  assign ram_we_o  = (state == ACCESS) && we_q;
  assign rvalid0_o = rvalid_q[0];
  assign rvalid1_o = rvalid_q[1];
  assign rdata_o   = ram_q_i;
endmodule
